line_sensor_conditioner: RTL and testbench

Conditions the three 12-bit line-sensor samples (left, centre, right) from the ADC controller before they reach the line follower. Each channel is thresholded with hysteresis, and the 3-bit pattern is debounced over consecutive samples. The block also detects grid nodes (all three sensors on black) and counts them, and flags line loss. Outputs drive the line-follower steering and node-tracking logic directly.

---
 rtl/line_sensor_conditioner.sv | 160 ++++++++++++++++
 tb/tb_line_sensor_conditioner.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/line_sensor_conditioner.sv
// Line-sensor conditioner: per-channel hysteresis thresholding, pattern
// debounce, grid-node detection/counting and line-loss indication.
// All state advances only on cycles where sample_valid is high.
module line_sensor_conditioner #(
  parameter logic [11:0] TH_HI        = 12'd1400,
  parameter logic [11:0] TH_LO        = 12'd1000,
  parameter int          DEBOUNCE     = 3,
  parameter int          NODE_GAP     = 4,
  parameter int          LOST_SAMPLES = 8
) (
  input  logic        clk_50M,
  input  logic        reset,
  input  logic        sample_valid,
  input  logic [11:0] l_val,
  input  logic [11:0] c_val,
  input  logic [11:0] r_val,
  input  logic        clr_count,
  output logic [2:0]  line_pat,
  output logic        pat_valid,
  output logic        node_pulse,
  output logic [5:0]  node_count,
  output logic        lost_line
);

  typedef enum logic [1:0] {FOLLOW, ON_NODE, LEAVING} state_t;

  localparam logic [3:0] DEB_TH  = 4'(DEBOUNCE);
  localparam logic [3:0] GAP_TH  = 4'(NODE_GAP);
  localparam logic [7:0] LOST_TH = 8'(LOST_SAMPLES);

  // Bit order of every pattern is {left, centre, right}.
  logic [11:0] val [3];
  assign val[2] = l_val;
  assign val[1] = c_val;
  assign val[0] = r_val;

  state_t      state_reg, state_next;
  logic [2:0]  raw_reg, raw_next;
  logic [2:0]  raw_thr;
  logic [3:0]  deb_cnt_reg, deb_cnt_next;
  logic [2:0]  line_pat_reg, line_pat_next;
  logic        pat_valid_reg, pat_valid_next;
  logic        node_pulse_reg, node_pulse_next;
  logic [5:0]  node_count_reg, node_count_next;
  logic [3:0]  gap_cnt_reg, gap_cnt_next;
  logic [7:0]  lost_cnt_reg, lost_cnt_next;
  logic        lost_line_reg, lost_line_next;

  // Hysteresis: set at/above TH_HI, clear below TH_LO, otherwise hold.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_hyst
      assign raw_thr[gi] = (val[gi] >= TH_HI) ? 1'b1 :
                           (val[gi] <  TH_LO) ? 1'b0 : raw_reg[gi];
    end
  endgenerate

  // Next-state logic: debounce, node FSM, node counter and lost-line counter.
  always_comb begin
    raw_next        = raw_reg;
    deb_cnt_next    = deb_cnt_reg;
    line_pat_next   = line_pat_reg;
    pat_valid_next  = sample_valid;
    node_pulse_next = 1'b0;
    node_count_next = node_count_reg;
    gap_cnt_next    = gap_cnt_reg;
    lost_cnt_next   = lost_cnt_reg;
    lost_line_next  = lost_line_reg;
    state_next      = state_reg;

    if (sample_valid) begin
      raw_next = raw_thr;

      // Run length of the current raw pattern, saturating at 15.
      if (raw_thr == raw_reg) begin
        deb_cnt_next = (deb_cnt_reg == 4'd15) ? 4'd15 : deb_cnt_reg + 4'd1;
      end else begin
        deb_cnt_next = 4'd1;
      end
      if (deb_cnt_next >= DEB_TH) begin
        line_pat_next = raw_thr;
      end

      // Node tracking runs on the freshly debounced pattern.
      case (state_reg)
        FOLLOW: begin
          if (line_pat_next == 3'b111) begin
            state_next      = ON_NODE;
            node_pulse_next = 1'b1;
            node_count_next = node_count_reg + 6'd1;
          end
        end
        ON_NODE: begin
          if (line_pat_next != 3'b111) begin
            gap_cnt_next = 4'd1;
            state_next   = (GAP_TH <= 4'd1) ? FOLLOW : LEAVING;
          end
        end
        LEAVING: begin
          if (line_pat_next == 3'b111) begin
            state_next = ON_NODE;
          end else begin
            gap_cnt_next = gap_cnt_reg + 4'd1;
            if (gap_cnt_next >= GAP_TH) begin
              state_next = FOLLOW;
            end
          end
        end
        default: state_next = FOLLOW;
      endcase

      // Line loss: run of all-white debounced samples, cleared by any sighting.
      if (line_pat_next == 3'b000) begin
        lost_cnt_next  = (lost_cnt_reg == 8'd255) ? 8'd255 : lost_cnt_reg + 8'd1;
        lost_line_next = (lost_cnt_next >= LOST_TH);
      end else begin
        lost_cnt_next  = 8'd0;
        lost_line_next = 1'b0;
      end
    end

    // Clear wins over a same-cycle increment; the pulse is unaffected.
    if (clr_count) begin
      node_count_next = 6'd0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_50M) begin
    if (reset) begin
      state_reg      <= FOLLOW;
      raw_reg        <= 3'b000;
      deb_cnt_reg    <= 4'd0;
      line_pat_reg   <= 3'b000;
      pat_valid_reg  <= 1'b0;
      node_pulse_reg <= 1'b0;
      node_count_reg <= 6'd0;
      gap_cnt_reg    <= 4'd0;
      lost_cnt_reg   <= 8'd0;
      lost_line_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      raw_reg        <= raw_next;
      deb_cnt_reg    <= deb_cnt_next;
      line_pat_reg   <= line_pat_next;
      pat_valid_reg  <= pat_valid_next;
      node_pulse_reg <= node_pulse_next;
      node_count_reg <= node_count_next;
      gap_cnt_reg    <= gap_cnt_next;
      lost_cnt_reg   <= lost_cnt_next;
      lost_line_reg  <= lost_line_next;
    end
  end

  assign line_pat   = line_pat_reg;
  assign pat_valid  = pat_valid_reg;
  assign node_pulse = node_pulse_reg;
  assign node_count = node_count_reg;
  assign lost_line  = lost_line_reg;

endmodule

// File: tb/tb_line_sensor_conditioner.sv
// Directed bench for line_sensor_conditioner: two instances share stimulus,
// one with DEBOUNCE=1 (dut1) and one with DEBOUNCE=3 (dut3).
module tb_line_sensor_conditioner;

  logic        clk_50M = 1'b0;
  logic        reset;
  logic        sample_valid;
  logic [11:0] l_val, c_val, r_val;
  logic        clr_count;

  logic [2:0] p1, p3;
  logic       pv1, pv3, np1, np3, ll1, ll3;
  logic [5:0] nc1, nc3;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk_50M = ~clk_50M;

  line_sensor_conditioner #(.DEBOUNCE(1)) dut1 (
    .clk_50M(clk_50M), .reset(reset), .sample_valid(sample_valid),
    .l_val(l_val), .c_val(c_val), .r_val(r_val), .clr_count(clr_count),
    .line_pat(p1), .pat_valid(pv1), .node_pulse(np1),
    .node_count(nc1), .lost_line(ll1)
  );

  line_sensor_conditioner #(.DEBOUNCE(3)) dut3 (
    .clk_50M(clk_50M), .reset(reset), .sample_valid(sample_valid),
    .l_val(l_val), .c_val(c_val), .r_val(r_val), .clr_count(clr_count),
    .line_pat(p3), .pat_valid(pv3), .node_pulse(np3),
    .node_count(nc3), .lost_line(ll3)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One sample strobe; returns 1 time unit after the capturing edge.
  task automatic send_raw(input logic [11:0] l, input logic [11:0] c, input logic [11:0] r);
    l_val = l; c_val = c; r_val = r;
    sample_valid = 1'b1;
    @(posedge clk_50M); #1;
    sample_valid = 1'b0;
    $display("sample l=%0d c=%0d r=%0d -> pat1=%b pat3=%b pulse=%b count=%0d lost=%b",
             l, c, r, p1, p3, np1, nc1, ll1);
  endtask

  // Drive a clean pattern: 2000 is above TH_HI, 200 below TH_LO.
  task automatic send(input logic [2:0] p);
    send_raw(p[2] ? 12'd2000 : 12'd200,
             p[1] ? 12'd2000 : 12'd200,
             p[0] ? 12'd2000 : 12'd200);
  endtask

  task automatic do_reset();
    reset = 1'b1; sample_valid = 1'b0;
    @(posedge clk_50M); #1;
    reset = 1'b0;
  endtask

  logic [2:0] node_seq   [11] = '{3'b010, 3'b111, 3'b111, 3'b010, 3'b010, 3'b111,
                                  3'b010, 3'b010, 3'b010, 3'b010, 3'b111};
  logic       node_pulse_exp [11] = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1};
  logic [5:0] node_count_exp [11] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 2};
  logic [11:0] hyst_c    [4] = '{12'd1500, 12'd1200, 12'd900, 12'd1200};
  logic [2:0]  hyst_exp  [4] = '{3'b010, 3'b010, 3'b000, 3'b000};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; sample_valid = 1'b1; clr_count = 1'b0;
    l_val = 12'd2000; c_val = 12'd2000; r_val = 12'd2000;

    // Reset overrides valid samples.
    repeat (3) @(posedge clk_50M);
    #1;
    check("rst_pat",   8'(p1),  8'd0);
    check("rst_valid", 8'(pv1), 8'd0);
    check("rst_pulse", 8'(np1), 8'd0);
    check("rst_count", 8'(nc1), 8'd0);
    check("rst_lost",  8'(ll1), 8'd0);
    check("rst_pat3",  8'(p3),  8'd0);
    reset = 1'b0; sample_valid = 1'b0;

    send_raw(12'd200, 12'd200, 12'd200);
    check("first_pat",   8'(p1),  8'd0);
    check("first_valid", 8'(pv1), 8'd1);
    @(posedge clk_50M); #1;
    check("valid_drop",  8'(pv1), 8'd0);

    // Hysteresis on the centre channel.
    for (int i = 0; i < 4; i++) begin
      send_raw(12'd200, hyst_c[i], 12'd200);
      check($sformatf("hyst_%0d", i), 8'(p1), 8'(hyst_exp[i]));
    end

    // Debounce with DEBOUNCE=3.
    do_reset();
    send(3'b010); check("deb_010_a", 8'(p3), 8'd0);
    send(3'b010); check("deb_010_b", 8'(p3), 8'd0);
    send(3'b011); check("deb_011_a", 8'(p3), 8'd0);
    send(3'b011); check("deb_011_b", 8'(p3), 8'd0);
    send(3'b011); check("deb_011_c", 8'(p3), 8'd3);
    send(3'b001); check("deb_transient", 8'(p3), 8'd3);

    // Node detection with gap (dut1, NODE_GAP=4).
    do_reset();
    for (int i = 0; i < 11; i++) begin
      send(node_seq[i]);
      check($sformatf("node_pulse_%0d", i), 8'(np1), 8'(node_pulse_exp[i]));
      check($sformatf("node_count_%0d", i), 8'(nc1), 8'(node_count_exp[i]));
    end
    repeat (4) send(3'b010);

    // Wrap 63 -> 0.
    for (int i = 0; i < 61; i++) begin
      send(3'b111);
      repeat (4) send(3'b010);
    end
    check("count_63", 8'(nc1), 8'd63);
    send(3'b111);
    check("wrap_count", 8'(nc1), 8'd0);
    check("wrap_pulse", 8'(np1), 8'd1);
    repeat (4) send(3'b010);
    send(3'b111);
    repeat (4) send(3'b010);
    check("count_1", 8'(nc1), 8'd1);

    // Clear coincident with node entry.
    clr_count = 1'b1;
    send(3'b111);
    clr_count = 1'b0;
    check("clr_count", 8'(nc1), 8'd0);
    check("clr_pulse", 8'(np1), 8'd1);

    // Lost line.
    do_reset();
    repeat (7) send(3'b000);
    check("lost_7", 8'(ll1), 8'd0);
    send(3'b000); check("lost_8", 8'(ll1), 8'd1);
    send(3'b000); check("lost_9", 8'(ll1), 8'd1);
    send(3'b010); check("lost_clear", 8'(ll1), 8'd0);
    check("lost_clear_pat", 8'(p1), 8'd2);
    send(3'b000); check("lost_restart", 8'(ll1), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
